// File: rtl/pulse_gen_pkg.sv
// Shared types, default timing constants and a width helper for the
// button-driven enable pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_REPEAT_DELAY    = 20;
    localparam int unsigned DEF_REPEAT_RATE     = 5;
    localparam int unsigned DEF_CNT_W           = 8;

    // Number of bits needed to represent the value v (at least 1).
    function automatic int unsigned bits_for(input int unsigned v);
        int unsigned n;
        n = 1;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/enable_pulse_gen_if.sv
// Button-side and counter-side signals of the enable pulse generator.
interface enable_pulse_gen_if;
    logic btn_in;
    logic repeat_en;
    logic enable;
    logic btn_level;
    logic holding;

    modport master (
        output btn_in,
        output repeat_en,
        input  enable,
        input  btn_level,
        input  holding
    );

    modport slave (
        input  btn_in,
        input  repeat_en,
        output enable,
        output btn_level,
        output holding
    );
endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; the rise/fall
// strobes flag the edge on which btn_level is about to change.
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic rise,
    output logic fall
);

    logic             s1;
    logic             btn_s;
    logic [CNT_W-1:0] deb_cnt;
    logic             mismatch;
    logic             settle;

    assign mismatch = (btn_s != btn_level);
    assign settle   = mismatch && (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise     = settle && !btn_level;
    assign fall     = settle && btn_level;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (s1 -> btn_s stays two stages).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= 1'b0;
            btn_s     <= 1'b0;
            deb_cnt   <= '0;
            btn_level <= 1'b0;
        end else begin
            s1    <= btn_in;
            btn_s <= s1;
            if (!mismatch) begin
                deb_cnt <= '0;
            end else if (settle) begin
                btn_level <= ~btn_level;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/enable_pulse_gen.sv
// Turns a bouncing push-button into single-cycle counter enable pulses,
// with optional auto-repeat while the button is held.
module enable_pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    enable_pulse_gen_if.slave   bus
);

    if (bits_for(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) > CNT_W) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured cycle counts");
    end

    state_t           state;
    logic [CNT_W-1:0] rpt_cnt;
    logic             rise;
    logic             fall;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (bus.btn_in),
        .btn_level (bus.btn_level),
        .rise      (rise),
        .fall      (fall)
    );

    // A falling level is checked first in every held state, so release
    // always beats a coincident repeat match and never emits a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rpt_cnt     <= '0;
            bus.enable  <= 1'b0;
            bus.holding <= 1'b0;
        end else begin
            // NOTE: enable defaults low every edge, so it can only ever be a
            // one-cycle pulse on the branches that set it.
            bus.enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state       <= HELD;
                        bus.enable  <= 1'b1;
                        bus.holding <= 1'b1;
                        rpt_cnt     <= '0;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state       <= IDLE;
                        bus.holding <= 1'b0;
                        rpt_cnt     <= '0;
                    end else if (!bus.repeat_en) begin
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        state      <= REPEAT;
                        bus.enable <= 1'b1;
                        rpt_cnt    <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state       <= IDLE;
                        bus.holding <= 1'b0;
                        rpt_cnt     <= '0;
                    end else if (!bus.repeat_en) begin
                        state   <= HELD;
                        rpt_cnt <= '0;
                    end else if (rpt_cnt == CNT_W'(REPEAT_RATE - 1)) begin
                        bus.enable <= 1'b1;
                        rpt_cnt    <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.holding <= 1'b0;
                    rpt_cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Directed bench: stimulus pushes expected enable-pulse cycles into a queue,
// a monitor pops and compares on every observed pulse.
module tb_enable_pulse_gen;

    logic clk;
    logic reset;
    int   cyc;
    int   passed;
    int   total;
    int   exp_q[$];

    enable_pulse_gen_if bus ();

    enable_pulse_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        passed = 0;
        total  = 0;
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Monitor: every enable pulse must match the next expected cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.enable === 1'b1) begin
                int e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("pulse_cycle", cyc, e);
            end
        end
    end

    // Release the button and check the debounced fall timing.
    task automatic release_btn(input string tag);
        int m;
        @(negedge clk);
        m = cyc;
        bus.btn_in = 1'b0;
        repeat (5) @(negedge clk);
        check({tag, "_level_before_fall"}, bus.btn_level, 1);
        @(negedge clk);
        check({tag, "_fall_cycle"}, cyc, m + 6);
        check({tag, "_level_fallen"}, bus.btn_level, 0);
        check({tag, "_holding_clear"}, bus.holding, 0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int n;
        int p;
        int r;
        logic bounce [8];
        bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // 1: reset held with the button pressed
        bus.btn_in    = 1'b1;
        bus.repeat_en = 1'b0;
        reset         = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_enable", bus.enable, 0);
            check("rst_btn_level", bus.btn_level, 0);
            check("rst_holding", bus.holding, 0);
        end
        @(negedge clk);
        bus.btn_in = 1'b0;
        reset      = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_level", bus.btn_level, 0);

        // 2: single press, no repeat
        @(negedge clk);
        n = cyc;
        bus.btn_in = 1'b1;
        exp_q.push_back(n + 6);
        repeat (5) @(negedge clk);
        check("t2_level_before", bus.btn_level, 0);
        check("t2_holding_before", bus.holding, 0);
        @(negedge clk);
        check("t2_level_up", bus.btn_level, 1);
        check("t2_holding_up", bus.holding, 1);
        repeat (94) @(negedge clk);
        check("t2_still_holding", bus.holding, 1);
        release_btn("t2");

        // 3: bounce shorter than the debounce window
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.btn_in = bounce[i];
            check("t3_level_during_bounce", bus.btn_level, 0);
        end
        repeat (8) begin
            @(negedge clk);
            check("t3_level_after_bounce", bus.btn_level, 0);
        end

        // 4: auto-repeat, then repeat disabled, then re-enabled from HELD
        @(negedge clk);
        n = cyc;
        bus.btn_in    = 1'b1;
        bus.repeat_en = 1'b1;
        exp_q.push_back(n + 6);
        for (int k = 0; k < 7; k++) exp_q.push_back(n + 26 + 5 * k);
        repeat (58) @(negedge clk);
        bus.repeat_en = 1'b0;
        repeat (30) @(negedge clk);
        check("t4_holding_no_repeat", bus.holding, 1);
        check("t4_all_repeats_seen", exp_q.size(), 0);
        @(negedge clk);
        p = cyc;
        bus.repeat_en = 1'b1;
        exp_q.push_back(p + 20);
        repeat (21) @(negedge clk);
        bus.repeat_en = 1'b0;
        repeat (10) @(negedge clk);

        // 5: release after repeat
        release_btn("t5");

        // 6: reset mid-REPEAT with the button still pressed
        @(negedge clk);
        n = cyc;
        bus.btn_in    = 1'b1;
        bus.repeat_en = 1'b1;
        exp_q.push_back(n + 6);
        exp_q.push_back(n + 26);
        exp_q.push_back(n + 31);
        exp_q.push_back(n + 36);
        repeat (36) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("t6_rst_enable", bus.enable, 0);
        check("t6_rst_holding", bus.holding, 0);
        check("t6_rst_level", bus.btn_level, 0);
        @(negedge clk);
        @(negedge clk);
        r = cyc;
        reset = 1'b1;
        exp_q.push_back(r + 6);
        exp_q.push_back(r + 26);
        exp_q.push_back(r + 31);
        repeat (5) @(negedge clk);
        check("t6_level_before", bus.btn_level, 0);
        @(negedge clk);
        check("t6_level_up", bus.btn_level, 1);
        check("t6_holding_up", bus.holding, 1);
        repeat (26) @(negedge clk);
        bus.repeat_en = 1'b0;
        bus.btn_in    = 1'b0;
        repeat (15) @(negedge clk);
        check("t6_holding_end", bus.holding, 0);
        check("pending_pulses", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
